spi_frame_sched: RTL and testbench
==================================

Name: spi_frame_sched

Overview:
- Round-robin scheduler and sequencer for the board's single SPI byte-transmit path.
- Up to NREQ requesters each present byte frames over a valid/ready handshake; the block grants one requester per frame.
- It serializes the granted requester's bytes MSB-first onto sck/sdi and frames each transfer with load.
- Sits between the byte producers in the FPGA and the external SPI peripheral; it owns the link exclusively.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CLKDIV, 2, clk cycles per sck half-period (>=1).
- GAP, 2, idle clk cycles between frames with load low (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NREQ  packed byte lanes.
- req_last  in  NREQ  byte on lane i is the final byte of its frame.
- req_ready  out  NREQ  byte on lane i accepted this cycle (handshake = valid & ready).
- grant  out  NREQ  one-hot owner of the current frame; 0 when idle.
- sck  out  1  SPI clock, idles low.
- sdi  out  1  SPI data, MSB first, changes only while sck low.
- load  out  1  high for the whole frame (chip select, active high).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-clk pulse when a frame's last bit completes.

Behaviour:
- Reset (async, any state): state=IDLE, sck=0, sdi=0, load=0, req_ready=0, grant=0, busy=0, frame_done=0, rr pointer=0 (requester 0 highest priority).
- Counters: bit counter 3 bits, divider counter ceil(log2(CLKDIV)) bits, gap counter ceil(log2(GAP+1)) bits.
- IDLE:
  - Any req_valid high → choose the first valid index at or after the rr pointer, wrapping modulo NREQ.
  - Register grant one-hot, go FETCH.
  - load stays 0 this cycle.
- FETCH:
  - load=1, sck=0.
  - req_ready[g] = req_valid[g] combinationally; other ready bits are 0.
  - On handshake: capture byte into the shift register, capture last, sdi=byte[7] next cycle, go SHIFT.
  - If req_valid[g] is low: stall in FETCH indefinitely with load held high. A mid-frame stall never releases the grant.
- SHIFT, per bit:
  - CLKDIV clks with sck=0, then CLKDIV clks with sck=1. The peripheral samples on the sck rising edge.
  - On the falling transition, shift left and present the next bit on sdi.
  - After the high phase of bit 0:
    - last=0 → FETCH (sck returns low).
    - last=1 → GAP.
- Byte timing: 1 FETCH clk + 16*CLKDIV clks, i.e. 33 clks at defaults when valid is already high.
- GAP:
  - Entry cycle: frame_done=1 for exactly one clk, load=0, sck=0, sdi=0, grant=0.
  - rr pointer = (g+1) mod NREQ.
  - Hold GAP clks, then IDLE.
- Latency: req_valid high in IDLE at edge n → load high after edge n+1 → first handshake at edge n+2 → first sck rise at edge n+2+CLKDIV.
- Requests arriving while busy are ignored for arbitration until IDLE. Their ready stays 0 and data is not consumed.
- Simultaneous valid from several requesters: rr pointer decides; fairness is per frame, not per byte.
- req_data/req_last on non-granted lanes are don't-care.
- Reset mid-frame: outputs go to reset values immediately (load drops asynchronously). The partial byte is discarded, and the requester must resend the frame.
- No combinational path from req_* to sck/sdi/load; those are registered.

Decomposition:
- Shared package spi_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, FETCH, SHIFT, GAP};
  - constant BYTE_BITS=8;
  - localparam helpers for counter widths.
- Natural sub-module: rr_arbiter (NREQ request vector + pointer in → one-hot grant out, purely combinational). Instantiated once; the FSM registers its output.

Test Plan:
- Single byte: req0 sends 0xA5, last=1 → load high 33 clks; sdi sampled on sck rises = 1,0,1,0,0,1,0,1; frame_done one pulse; grant=01 then 00; idle after GAP.
- Contention: req0 and req1 both valid from reset, 1-byte frames 0x3C and 0xC3 → req0 frame first, GAP, then req1. The next frame with both valid again goes to req0 after req1 completes.
- Multi-byte with stall: req1 sends 0x12, then drops valid 10 clks, then 0x34 last.
  - load stays high throughout; sck low during the stall.
  - sdi stream = 0x12 then 0x34; req_ready high exactly 2 cycles.
- Back-to-back same requester, other idle: req0 sends two frames consecutively → load low exactly GAP+1 clks between frames; grant=01 both times.
- Reset mid-frame: assert reset during bit 4 of byte 0x FF → sck, sdi, load, grant, busy go 0 immediately. After release, new request from req1 is granted (pointer = 0 but req0 idle).
- CLKDIV=1, GAP=1 build: single byte 0x80 → sck period 2 clks, frame load-high 17 clks, sdi high only for the first bit.

Source files
------------

// File: rtl/spi_frame_sched_pkg.sv
// Shared types and helpers for the SPI frame scheduler.
package spi_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP} state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_frame_sched_rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Scan from the pointer position, the first asserted request wins
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_sched.sv
// Per-frame round-robin scheduler and MSB-first byte serializer for the SPI link.
module spi_frame_sched
    import spi_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int CLKDIV = 2,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              sck,
    output logic              sdi,
    output logic              load,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = cnt_w(CLKDIV);
    localparam int GAP_W = cnt_w(GAP + 1);
    localparam int BIT_W = cnt_w(BYTE_BITS);
    localparam int PTR_W = cnt_w(NREQ);

    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [7:0]       r_shreg, w_shreg_nxt;
    logic             r_last, w_last_nxt;
    logic             r_sck, w_sck_nxt;
    logic             r_sdi, w_sdi_nxt;
    logic             r_load, w_load_nxt;
    logic             r_done, w_done_nxt;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [7:0]       w_byte;
    logic             w_lane_last;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_hs;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt)
    );

    // Select the owning lane's byte, last flag and index
    always_comb begin
        w_byte      = '0;
        w_lane_last = 1'b0;
        w_gidx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_byte      = req_data[i*8 +: 8];
                w_lane_last = req_last[i];
                w_gidx      = PTR_W'(i);
            end
        end
    end

    assign w_hs      = (r_state == FETCH) && |(req_valid & r_grant);
    assign w_ptr_inc = (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    assign req_ready = (r_state == FETCH) ? (req_valid & r_grant) : '0;

    // Next-state and next-output logic; all link outputs are registered below
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_shreg_nxt = r_shreg;
        w_last_nxt  = r_last;
        w_sck_nxt   = r_sck;
        w_sdi_nxt   = r_sdi;
        w_load_nxt  = r_load;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_grant_nxt = w_arb_gnt;
                    w_load_nxt  = 1'b1;
                    w_sck_nxt   = 1'b0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Without a handshake we simply wait here; grant and load hold
                if (w_hs) begin
                    w_shreg_nxt = w_byte;
                    w_last_nxt  = w_lane_last;
                    w_sdi_nxt   = w_byte[7];
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_div != DIV_W'(CLKDIV - 1)) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_div_nxt = '0;
                    if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                    end else begin
                        w_sck_nxt = 1'b0;
                        if (r_bit != BIT_W'(BYTE_BITS - 1)) begin
                            // Falling edge: advance to the next bit while sck is low
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                            w_sdi_nxt   = r_shreg[6];
                            w_bit_nxt   = r_bit + 1'b1;
                        end else if (r_last) begin
                            w_state_nxt = spi_pkg::GAP;
                            w_load_nxt  = 1'b0;
                            w_sdi_nxt   = 1'b0;
                            w_grant_nxt = '0;
                            w_done_nxt  = 1'b1;
                            w_ptr_nxt   = w_ptr_inc;
                            w_gap_nxt   = '0;
                        end else begin
                            w_state_nxt = FETCH;
                        end
                    end
                end
            end
            spi_pkg::GAP: begin
                if (r_gap == GAP_W'(GAP - 1)) w_state_nxt = IDLE;
                else                          w_gap_nxt   = r_gap + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops the link immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_shreg <= '0;
            r_last  <= 1'b0;
            r_sck   <= 1'b0;
            r_sdi   <= 1'b0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_shreg <= w_shreg_nxt;
            r_last  <= w_last_nxt;
            r_sck   <= w_sck_nxt;
            r_sdi   <= w_sdi_nxt;
            r_load  <= w_load_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign grant      = r_grant;
    assign sck        = r_sck;
    assign sdi        = r_sdi;
    assign load       = r_load;
    assign frame_done = r_done;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_frame_sched.sv
// Bench for spi_frame_sched: timeline model plus directed frame scenarios.
module tb_spi_frame_sched;

    localparam int N   = 2;
    localparam int CD0 = 2;
    localparam int G0  = 2;
    localparam int CD1 = 1;
    localparam int G1  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   cmp_on = 1'b0;

    logic [N-1:0]   rv  [2];
    logic [8*N-1:0] rd  [2];
    logic [N-1:0]   rl  [2];
    logic [N-1:0]   rdy [2];
    logic [N-1:0]   gnt [2];
    logic           sck [2];
    logic           sdi [2];
    logic           ld  [2];
    logic           bsy [2];
    logic           dn  [2];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_frame_sched #(.NREQ(N), .CLKDIV(CD0), .GAP(G0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
        .req_ready(rdy[0]), .grant(gnt[0]), .sck(sck[0]), .sdi(sdi[0]), .load(ld[0]),
        .busy(bsy[0]), .frame_done(dn[0])
    );

    spi_frame_sched #(.NREQ(N), .CLKDIV(CD1), .GAP(G1)) dut1 (
        .clk(clk), .reset(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
        .req_ready(rdy[1]), .grant(gnt[1]), .sck(sck[1]), .sdi(sdi[1]), .load(ld[1]),
        .busy(bsy[1]), .frame_done(dn[1])
    );

    // ---------------- timeline model ----------------
    // own: owning requester (-1 none); t: cycle within a byte (0 = waiting for
    // the byte, 1..16*CD = shifting); gap: remaining inter-frame idle cycles.
    int         m_own [2];
    int         m_t   [2];
    int         m_gap [2];
    int         m_ptr [2];
    logic [7:0] m_byte[2];
    logic       m_last[2];
    logic       m_sdi [2];

    function automatic int cdv(int d);
        return (d == 0) ? CD0 : CD1;
    endfunction

    function automatic int gv(int d);
        return (d == 0) ? G0 : G1;
    endfunction

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_own[d] <= -1; m_t[d] <= 0; m_gap[d] <= 0; m_ptr[d] <= 0;
                m_byte[d] <= '0; m_last[d] <= 1'b0; m_sdi[d] <= 1'b0;
            end else if (m_gap[d] > 0) begin
                m_gap[d] <= m_gap[d] - 1;
            end else if (m_own[d] < 0) begin
                if (rv[d] != '0) begin
                    m_own[d] <= pick(rv[d], m_ptr[d]);
                    m_t[d]   <= 0;
                end
            end else if (m_t[d] == 0) begin
                if (rv[d][m_own[d]]) begin
                    m_byte[d] <= rd[d][m_own[d]*8 +: 8];
                    m_last[d] <= rl[d][m_own[d]];
                    m_sdi[d]  <= rd[d][m_own[d]*8 + 7];
                    m_t[d]    <= 1;
                end
            end else if (m_t[d] == 16 * cdv(d)) begin
                if (m_last[d]) begin
                    m_gap[d] <= gv(d);
                    m_own[d] <= -1;
                    m_ptr[d] <= (m_own[d] + 1) % N;
                    m_sdi[d] <= 1'b0;
                end else begin
                    m_t[d] <= 0;
                end
            end else begin
                m_t[d]   <= m_t[d] + 1;
                m_sdi[d] <= m_byte[d][7 - m_t[d] / (2 * cdv(d))];
            end
        end
    end

    // Expected {ready, grant, sck, sdi, load, busy, frame_done}
    function automatic logic [2*N+4:0] expv(int d, logic [N-1:0] v);
        logic [N-1:0] g, r;
        logic s, q, l, b, f;
        g = '0; r = '0; s = 1'b0; q = 1'b0; l = 1'b0; b = 1'b0; f = 1'b0;
        if (m_own[d] >= 0) begin
            g[m_own[d]] = 1'b1;
            l = 1'b1;
            b = 1'b1;
            q = m_sdi[d];
            if (m_t[d] == 0) r = v & g;
            else             s = (((m_t[d] - 1) / cdv(d)) % 2) == 1;
        end else begin
            b = m_gap[d] > 0;
            f = m_gap[d] == gv(d);
        end
        return {r, g, s, q, l, b, f};
    endfunction

    logic [2*N+4:0] exp_v, act_v;

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int d = 0; d < 2; d++) begin
                exp_v = expv(d, rv[d]);
                act_v = {rdy[d], gnt[d], sck[d], sdi[d], ld[d], bsy[d], dn[d]};
                checks++;
                if (act_v !== exp_v) begin
                    errs++;
                    $display("FAIL cycle d%0d @%0t: got %b expected %b", d, $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- observation monitors ----------------
    bit           bq0[$];
    bit           bq1[$];
    logic [N-1:0] gq0[$];
    logic [N-1:0] gq1[$];
    int ldcnt[2], rdycnt[2], dncnt[2], sckhi[2], lowrun[2], lastlow[2], ldfall[2];
    bit           pld[2];
    bit [N-1:0]   pg[2];

    always @(posedge sck[0]) bq0.push_back(sdi[0]);
    always @(posedge sck[1]) bq1.push_back(sdi[1]);

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ld[d])        ldcnt[d]++;
            if (rdy[d] != '0) rdycnt[d]++;
            if (dn[d])        dncnt[d]++;
            if (sck[d])       sckhi[d]++;
            if (!ld[d] && pld[d]) ldfall[d]++;
            if (!ld[d]) lowrun[d]++;
            else begin
                if (!pld[d]) lastlow[d] = lowrun[d];
                lowrun[d] = 0;
            end
            if (gnt[d] != '0 && pg[d] == '0) begin
                if (d == 0) gq0.push_back(gnt[d]);
                else        gq1.push_back(gnt[d]);
            end
            pg[d]  = gnt[d];
            pld[d] = ld[d];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int qbyte(int d, int start);
        int b = 0;
        for (int i = 0; i < 8; i++)
            b = (b << 1) | ((d == 0) ? int'(bq0[start + i]) : int'(bq1[start + i]));
        return b;
    endfunction

    // Offer one byte on a lane and drop valid right after its handshake edge
    task automatic send(int d, int lane, logic [7:0] b, logic last);
        int n = 0;
        rd[d][lane*8 +: 8] = b;
        rl[d][lane]        = last;
        rv[d][lane]        = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (rdy[d][lane] !== 1'b1 && n < 400);
        chk("handshake_wait", rdy[d][lane], 1);
        @(posedge clk); #1;
        rv[d][lane] = 1'b0;
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bsy[d] !== 1'b0 && n < 1000);
        chk("idle_wait", bsy[d], 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int s, gs, l, r, dc, h, f;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rd[d] = '0; rl[d] = '0;
        end
        #1 rst = 1'b1;
        #2 cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load",  ld[0], 0);
        chk("rst_sck",   sck[0], 0);
        chk("rst_busy",  bsy[0], 0);
        chk("rst_grant", gnt[0], 0);
        chk("rst_ready", rdy[0], 0);
        chk("rst_done",  dn[1], 0);

        // Contention from reset: requester 0 wins, then requester 1
        @(posedge clk); #1;
        s = bq0.size(); gs = gq0.size();
        fork
            send(0, 0, 8'h3C, 1'b1);
            send(0, 1, 8'hC3, 1'b1);
            begin @(posedge clk); #1 rst = 1'b0; end
        join
        wait_idle(0);
        chk("cont1_g0", gq0[gs], 2'b01);
        chk("cont1_g1", gq0[gs+1], 2'b10);
        chk("cont1_b0", qbyte(0, s), 8'h3C);
        chk("cont1_b1", qbyte(0, s + 8), 8'hC3);

        // Both valid again: pointer has wrapped back to requester 0
        s = bq0.size(); gs = gq0.size();
        fork
            send(0, 0, 8'h3C, 1'b1);
            send(0, 1, 8'hC3, 1'b1);
        join
        wait_idle(0);
        chk("cont2_g0", gq0[gs], 2'b01);
        chk("cont2_g1", gq0[gs+1], 2'b10);
        chk("cont2_b0", qbyte(0, s), 8'h3C);

        // Single byte 0xA5 from requester 0
        s = bq0.size(); gs = gq0.size();
        l = ldcnt[0]; r = rdycnt[0]; dc = dncnt[0];
        send(0, 0, 8'hA5, 1'b1);
        wait_idle(0);
        chk("single_loadlen", ldcnt[0] - l, 33);
        chk("single_bits",    bq0.size() - s, 8);
        chk("single_byte",    qbyte(0, s), 8'hA5);
        chk("single_done",    dncnt[0] - dc, 1);
        chk("single_ready",   rdycnt[0] - r, 1);
        chk("single_grant",   gq0[gs], 2'b01);

        // Two-byte frame from requester 1 with a stall between bytes
        s = bq0.size(); gs = gq0.size();
        r = rdycnt[0]; f = ldfall[0];
        send(0, 1, 8'h12, 1'b0);
        repeat (42) @(posedge clk);
        #1;
        send(0, 1, 8'h34, 1'b1);
        wait_idle(0);
        chk("stall_b0",     qbyte(0, s), 8'h12);
        chk("stall_b1",     qbyte(0, s + 8), 8'h34);
        chk("stall_ready",  rdycnt[0] - r, 2);
        chk("stall_lfalls", ldfall[0] - f, 1);
        chk("stall_frames", gq0.size() - gs, 1);

        // Back-to-back frames from requester 0 alone
        gs = gq0.size();
        send(0, 0, 8'h55, 1'b1);
        send(0, 0, 8'h0F, 1'b1);
        wait_idle(0);
        chk("b2b_gaplen", lastlow[0], G0 + 1);
        chk("b2b_g0",     gq0[gs], 2'b01);
        chk("b2b_g1",     gq0[gs+1], 2'b01);

        // Reset during bit 4 of 0xFF
        send(0, 0, 8'hFF, 1'b1);
        repeat (18) @(posedge clk);
        #3;
        chk("prerst_sck",  sck[0], 1);
        chk("prerst_load", ld[0], 1);
        rst = 1'b1;
        #1;
        chk("midrst_sck",   sck[0], 0);
        chk("midrst_sdi",   sdi[0], 0);
        chk("midrst_load",  ld[0], 0);
        chk("midrst_grant", gnt[0], 0);
        chk("midrst_busy",  bsy[0], 0);
        @(posedge clk); #1 rst = 1'b0;
        s = bq0.size(); gs = gq0.size();
        send(0, 1, 8'h5A, 1'b1);
        wait_idle(0);
        chk("postrst_grant", gq0[gs], 2'b10);
        chk("postrst_byte",  qbyte(0, s), 8'h5A);

        // Fast build: CLKDIV=1, GAP=1, single byte 0x80
        s = bq1.size(); l = ldcnt[1]; h = sckhi[1]; dc = dncnt[1];
        send(1, 0, 8'h80, 1'b1);
        wait_idle(1);
        chk("fast_loadlen", ldcnt[1] - l, 17);
        chk("fast_sckhi",   sckhi[1] - h, 8);
        chk("fast_byte",    qbyte(1, s), 8'h80);
        chk("fast_done",    dncnt[1] - dc, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
